fc_layer_engine: RTL and testbench

Fully-connected layer compute stage for the CNN. Sits directly upstream of the FC weight ROM: generates its read address, consumes its 8-bit signed weight output one cycle later, and multiplies it against a locally buffered flattened feature vector (16 channels x 4 x 4 = 256 values). Produces one signed accumulator result per output neuron (32 neurons) on a valid/ready stream towards the classifier/argmax logic.

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_mac.sv | 40 ++++
 rtl/fc_layer_engine.sv | 125 ++++++++++++
 tb/tb_fc_layer_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the FC layer engine.
// Sizes match the 16x4x4 flattened feature map and 32 output neurons.
package fc_pkg;
    localparam int IN_NUM    = 256;
    localparam int OUT_NUM   = 32;
    localparam int FC_DATA_W = 8;
    localparam int FEAT_W    = 8;
    localparam int ACC_W     = 24;
    localparam int ADDR_W    = $clog2(IN_NUM * OUT_NUM);
    localparam int IDX_W     = $clog2(IN_NUM);
    localparam int ONUM_W    = $clog2(OUT_NUM);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        EMIT
    } state_e;
endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate: clear loads the first product,
// enable adds further products; no saturation needed at ACC_W.
module fc_mac
    import fc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic                        clr_i,
    input  logic signed [FC_DATA_W-1:0] w_i,
    input  logic signed [FEAT_W-1:0]    f_i,
    output logic signed [ACC_W-1:0]     acc_o
);
    logic signed [FC_DATA_W+FEAT_W-1:0] prod;
    logic signed [ACC_W-1:0]            prod_x;
    logic signed [ACC_W-1:0]            acc_q;
    logic signed [ACC_W-1:0]            acc_d;

    assign prod   = w_i * f_i;
    assign prod_x = ACC_W'(prod);

    // Next accumulator value: overwrite on clear, add otherwise.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = clr_i ? prod_x : acc_q + prod_x;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/fc_layer_engine.sv
// FC layer: buffers one feature frame, streams weights from ROM,
// and emits one accumulated result per neuron on a valid/ready port.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter bit RELU = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        feat_valid,
    input  logic signed [FEAT_W-1:0]    feat_data,
    output logic                        feat_ready,
    output logic [ADDR_W-1:0]           rom_raddr,
    input  logic signed [FC_DATA_W-1:0] rom_dout,
    output logic                        out_valid,
    output logic signed [ACC_W-1:0]     out_data,
    output logic [ONUM_W-1:0]           out_idx,
    input  logic                        out_ready,
    output logic                        busy
);
    localparam logic [IDX_W-1:0]  I_LAST = IDX_W'(IN_NUM - 1);
    localparam logic [ONUM_W-1:0] O_LAST = ONUM_W'(OUT_NUM - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     f_cnt_q;
    logic [IDX_W-1:0]     i_cnt_q;
    logic [IDX_W-1:0]     i_d_q;
    logic [ONUM_W-1:0]    o_cnt_q;
    logic [ADDR_W-1:0]    raddr_q;
    logic                 mac_v_q;
    logic                 clr_q;
    logic                 feat_ready_q;
    logic                 busy_q;
    logic                 out_valid_q;
    logic signed [FEAT_W-1:0] feat_buf [IN_NUM];
    logic signed [ACC_W-1:0]  acc;

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (feat_valid && f_cnt_q == I_LAST) state_d = COMPUTE;
            COMPUTE: if (i_cnt_q == I_LAST) state_d = DRAIN;
            DRAIN:   state_d = EMIT;
            EMIT:    if (out_ready) state_d = (o_cnt_q == O_LAST) ? LOAD : COMPUTE;
            default: state_d = LOAD;
        endcase
    end

    // Sequencer: counters, ROM address, MAC strobes and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            f_cnt_q      <= '0;
            i_cnt_q      <= '0;
            i_d_q        <= '0;
            o_cnt_q      <= '0;
            raddr_q      <= '0;
            mac_v_q      <= 1'b0;
            clr_q        <= 1'b0;
            feat_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            feat_ready_q <= (state_d == LOAD);
            busy_q       <= (state_d != LOAD);
            out_valid_q  <= (state_d == EMIT);
            mac_v_q      <= 1'b0;
            clr_q        <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (feat_valid) begin
                        f_cnt_q <= f_cnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    mac_v_q <= 1'b1;
                    clr_q   <= (i_cnt_q == '0);
                    i_d_q   <= i_cnt_q;
                    i_cnt_q <= i_cnt_q + 1'b1;
                    raddr_q <= raddr_q + 1'b1;
                end
                DRAIN: begin
                end
                EMIT: begin
                    if (out_ready) begin
                        if (o_cnt_q == O_LAST) begin
                            o_cnt_q <= '0;
                            raddr_q <= '0;
                        end else begin
                            o_cnt_q <= o_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Feature buffer write; contents need no reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && feat_valid) begin
            feat_buf[f_cnt_q] <= feat_data;
        end
    end

    fc_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_v_q),
        .clr_i (clr_q),
        .w_i   (rom_dout),
        .f_i   (feat_buf[i_d_q]),
        .acc_o (acc)
    );

    assign feat_ready = feat_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = o_cnt_q;
    assign rom_raddr  = raddr_q;
    assign out_data   = (RELU && acc[ACC_W-1]) ? '0 : acc;
endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine with a 1-cycle ROM model.
// Runs a plain and a RELU instance side by side on shared stimulus.
module tb_fc_layer_engine;
    import fc_pkg::*;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic feat_valid;
    logic signed [FEAT_W-1:0] feat_data;
    logic out_ready;
    logic signed [FC_DATA_W-1:0] rom_dout;

    logic feat_ready, out_valid, busy;
    logic [ADDR_W-1:0] rom_raddr;
    logic signed [ACC_W-1:0] out_data;
    logic [ONUM_W-1:0] out_idx;

    logic r_feat_ready, r_out_valid, r_busy;
    logic [ADDR_W-1:0] r_rom_raddr;
    logic signed [ACC_W-1:0] r_out_data;
    logic [ONUM_W-1:0] r_out_idx;

    logic signed [FC_DATA_W-1:0] rom [IN_NUM*OUT_NUM];
    int feat [IN_NUM];
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int addr_changes = 0;
    int addr_bad = 0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    fc_layer_engine #(.RELU(1'b0)) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(feat_ready), .rom_raddr(rom_raddr),
        .rom_dout(rom_dout), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy)
    );

    fc_layer_engine #(.RELU(1'b1)) dut_r (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(r_feat_ready), .rom_raddr(r_rom_raddr),
        .rom_dout(rom_dout), .out_valid(r_out_valid),
        .out_data(r_out_data), .out_idx(r_out_idx),
        .out_ready(out_ready), .busy(r_busy)
    );

    // ROM model: data one cycle after address.
    always @(posedge clk) rom_dout <= rom[rom_raddr];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Address walk tracker: every change must be a +1 step (mod 8192).
    always @(negedge clk) begin
        if (rom_raddr != prev_addr) begin
            addr_changes++;
            if (rom_raddr != ADDR_W'(prev_addr + 1'b1)) addr_bad++;
        end
        prev_addr = rom_raddr;
    end

    // Monitor: compare every accepted result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", int'(out_idx), -1);
            end else begin
                e = sb.pop_front();
                chk("out_idx", int'(out_idx), e.idx);
                chk("out_data", int'(out_data), e.val);
                chk("relu_valid", int'(r_out_valid), 1);
                chk("relu_data", int'(r_out_data), (e.val < 0) ? 0 : e.val);
                chk("relu_lockstep",
                    int'({r_busy, r_feat_ready, r_out_idx, r_rom_raddr}),
                    int'({busy, feat_ready, out_idx, rom_raddr}));
            end
        end
    end

    task automatic push_exp();
        for (int o = 0; o < OUT_NUM; o++) begin
            int s = 0;
            for (int i = 0; i < IN_NUM; i++) begin
                s += int'(rom[o*IN_NUM+i]) * feat[i];
            end
            sb.push_back('{o, s});
        end
    endtask

    task automatic load_frame(input int gap);
        for (int i = 0; i < IN_NUM; i++) begin
            feat_valid = 1'b1;
            feat_data  = FEAT_W'(feat[i]);
            if (i == IN_NUM - 1) chk("busy_before_last_beat", int'(busy), 0);
            @(posedge clk); #1;
            feat_valid = 1'b0;
            if (i == IN_NUM - 1) begin
                chk("compute_after_last_beat", int'({busy, feat_ready}), 2);
            end
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !feat_ready) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame_done_in_time", int'(n < 20000), 1);
        sb.delete();
    endtask

    task automatic wait_neuron_compute(input int o);
        int n = 0;
        while (!(busy && !out_valid && int'(out_idx) == o) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_neuron_compute", int'(n < 20000), 1);
    endtask

    task automatic fill(input int fv, input int wv);
        for (int i = 0; i < IN_NUM; i++) feat[i] = fv;
        for (int a = 0; a < IN_NUM*OUT_NUM; a++) rom[a] = FC_DATA_W'(wv);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        out_ready  = 1'b1;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_feat_ready", int'(feat_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_raddr", int'(rom_raddr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        rst = 1'b0;

        // Frame 1: all ones, plus full address walk.
        fill(1, 1);
        push_exp();
        addr_changes = 0;
        addr_bad = 0;
        load_frame(0);
        wait_done();
        chk("addr_changes", addr_changes, IN_NUM*OUT_NUM);
        chk("addr_bad_steps", addr_bad, 0);
        chk("sb_val_f1", 256, 256 * 1);

        // Frame 2: extreme negative products.
        fill(-128, -128);
        for (int o = 0; o < OUT_NUM; o++) sb.push_back('{o, 4194304});
        load_frame(0);
        wait_done();

        // Frame 3: large negative sum, RELU clamps to zero.
        fill(-128, 127);
        for (int o = 0; o < OUT_NUM; o++) sb.push_back('{o, -4161536});
        load_frame(0);
        wait_done();

        // Frame 4: identity-like weights, stall at neuron 5.
        for (int i = 0; i < IN_NUM; i++) feat[i] = i - 128;
        for (int o = 0; o < OUT_NUM; o++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                rom[o*IN_NUM+i] = (i == o) ? 8'sd1 : 8'sd0;
            end
            sb.push_back('{o, o - 128});
        end
        load_frame(0);
        wait_neuron_compute(5);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_emit", int'(n < 1000), 1);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_idx", int'(out_idx), 5);
            chk("stall_data", int'(out_data), -123);
            chk("stall_raddr", int'(rom_raddr), 6 * IN_NUM);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done();

        // Frame 5: reset during neuron 3 compute.
        for (int i = 0; i < IN_NUM; i++) feat[i] = (i % 4) - 1;
        for (int a = 0; a < IN_NUM*OUT_NUM; a++) rom[a] = 8'sd2;
        push_exp();
        load_frame(0);
        wait_neuron_compute(3);
        repeat (40) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        chk("midrst_feat_ready", int'(feat_ready), 1);
        chk("midrst_raddr", int'(rom_raddr), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_idx", int'(out_idx), 0);
        rst = 1'b0;

        // Frame 6: gapped load, beats during compute ignored.
        for (int i = 0; i < IN_NUM; i++) feat[i] = (i % 7) - 3;
        for (int o = 0; o < OUT_NUM; o++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                rom[o*IN_NUM+i] = FC_DATA_W'(((o + i) % 5) - 2);
            end
        end
        push_exp();
        load_frame(2);
        feat_valid = 1'b1;
        feat_data  = 8'sh55;
        repeat (20) begin
            @(posedge clk); #1;
        end
        feat_valid = 1'b0;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
